// File: rtl/ws2812_pkg.sv
// Shared types, constants and helpers for the WS2812 frame controller.
// Optional per-frame brightness scaling is enabled by defining WS2812_BRIGHTNESS_EN.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_LATCH = 3'd4
  } state_e;

  localparam int BitsPerLed = 24;

  // Wire order: G[7:0], R[7:0], B[7:0], each channel MSB first.
  typedef enum logic {ORDER_GRB_MSB_FIRST = 1'b0} bit_order_e;
  localparam bit_order_e BitOrder = ORDER_GRB_MSB_FIRST;

  // Rounds up so that a pulse is never shorter than requested.
  function automatic int ns_to_cyc(input int ns, input int clk_freq_mhz);
    return (ns * clk_freq_mhz + 999) / 1000;
  endfunction

  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] br);
    return 8'((({8'd0, c} * {8'd0, br}) + {8'd0, c}) >> 8);
  endfunction

  function automatic logic [23:0] scale_pixel(input logic [23:0] px, input logic [7:0] br);
    return {scale_chan(px[23:16], br), scale_chan(px[15:8], br), scale_chan(px[7:0], br)};
  endfunction

endpackage

// File: rtl/ws2812_frame_ctrl_bit_encoder.sv
// Single-bit WS2812 waveform generator: a load starts a TBitCyc-long period whose
// high time depends on the loaded bit; bit_last flags the final cycle of the period.
module ws2812_bit_encoder #(
  parameter int T0hCyc  = 28,
  parameter int T1hCyc  = 56,
  parameter int TBitCyc = 88
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic bit_val,
  output logic ws,
  output logic bit_last
);

  localparam int PhW = (TBitCyc > 1) ? $clog2(TBitCyc) : 1;
  localparam logic [PhW-1:0] PhLast = PhW'(TBitCyc - 1);
  localparam logic [PhW-1:0] T0h    = PhW'(T0hCyc);
  localparam logic [PhW-1:0] T1h    = PhW'(T1hCyc);

  logic [PhW-1:0] phase_q, phase_d, phase_inc, hi_cyc;
  logic           active_q, active_d;
  logic           bit_q, bit_d;
  logic           ws_q, ws_d;

  assign phase_inc = phase_q + PhW'(1);
  assign hi_cyc    = bit_q ? T1h : T0h;

  // Next-state logic for the bit period
  always_comb begin
    phase_d  = phase_q;
    active_d = active_q;
    bit_d    = bit_q;
    ws_d     = 1'b0;
    if (load) begin
      phase_d  = '0;
      active_d = 1'b1;
      bit_d    = bit_val;
      ws_d     = 1'b1;
    end else if (active_q && (phase_q != PhLast)) begin
      phase_d = phase_inc;
      ws_d    = (phase_inc < hi_cyc);
    end else begin
      phase_d  = '0;
      active_d = 1'b0;
    end
  end

  // Bit period registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= '0;
      active_q <= 1'b0;
      bit_q    <= 1'b0;
      ws_q     <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      bit_q    <= bit_d;
      ws_q     <= ws_d;
    end
  end

  assign ws       = ws_q;
  assign bit_last = active_q && (phase_q == PhLast);

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame scheduler: fetches NumLeds GRB pixels from a 1-cycle-latency RAM and
// streams them gap-free, then latches. Define WS2812_BRIGHTNESS_EN to add brightness scaling.
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int NumLeds   = 64,
  parameter int T0hCyc    = ns_to_cyc(400, 70),
  parameter int T1hCyc    = ns_to_cyc(800, 70),
  parameter int TBitCyc   = ns_to_cyc(1250, 70),
  parameter int TResetCyc = ns_to_cyc(300000, 70),
  parameter int AddrW     = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  output logic             pix_rd,
  output logic [AddrW-1:0] pix_addr,
  input  logic [23:0]      pix_data,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]       brightness,
`endif
  output logic             ws,
  output logic             busy,
  output logic             frame_done
);

  localparam int LatW = $clog2(TResetCyc + 1);
  localparam logic [LatW-1:0]  LatLast = LatW'(TResetCyc - 1);
  localparam logic [AddrW-1:0] LastIdx = AddrW'(NumLeds - 1);

  state_e                state_q, state_d;
  logic [BitsPerLed-2:0] shreg_q, shreg_d;
  logic [BitsPerLed-1:0] next_q, next_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [AddrW-1:0]      pix_idx_q, pix_idx_d;
  logic [AddrW-1:0]      pix_addr_q, pix_addr_d;
  logic                  pix_rd_q, pix_rd_d;
  logic                  cap_q, cap_d;
  logic [LatW-1:0]       lat_cnt_q, lat_cnt_d;
  logic                  after_frame_q, after_frame_d;
  logic                  frame_done_q, frame_done_d;
  logic                  start_ready_q, start_ready_d;
  logic                  busy_q, busy_d;
  logic                  enc_load, enc_bit, enc_bit_last;
  logic [23:0]           pix_in;

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] bright_q, bright_d;
  assign pix_in   = scale_pixel(pix_data, bright_q);
  assign bright_d = (state_q == ST_IDLE && start_valid) ? brightness : bright_q;

  // Brightness is frozen for the whole frame at the start handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright_q <= 8'hFF;
    end else begin
      bright_q <= bright_d;
    end
  end
`else
  assign pix_in = pix_data;
`endif

  // Frame sequencing, prefetch and shift control
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    next_d        = next_q;
    bit_cnt_d     = bit_cnt_q;
    pix_idx_d     = pix_idx_q;
    pix_addr_d    = pix_addr_q;
    pix_rd_d      = 1'b0;
    cap_d         = pix_rd_q;
    lat_cnt_d     = lat_cnt_q;
    after_frame_d = after_frame_q;
    frame_done_d  = 1'b0;
    enc_load      = 1'b0;
    enc_bit       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d    = ST_FETCH;
          pix_rd_d   = 1'b1;
          pix_addr_d = '0;
          pix_idx_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d   = ST_SHIFT;
        shreg_d   = pix_in[22:0];
        bit_cnt_d = 5'd23;
        enc_load  = 1'b1;
        enc_bit   = pix_in[23];
        if (pix_addr_q != LastIdx) begin
          pix_rd_d   = 1'b1;
          pix_addr_d = pix_addr_q + AddrW'(1);
        end else begin
          pix_rd_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        // cap_q marks the cycle in which the prefetched pixel is on pix_data
        if (cap_q) begin
          next_d = pix_in;
        end else begin
          next_d = next_q;
        end
        if (enc_bit_last) begin
          if (bit_cnt_q != 5'd0) begin
            bit_cnt_d = bit_cnt_q - 5'd1;
            shreg_d   = {shreg_q[21:0], 1'b0};
            enc_load  = 1'b1;
            enc_bit   = shreg_q[22];
          end else if (pix_idx_q != LastIdx) begin
            pix_idx_d = pix_idx_q + AddrW'(1);
            bit_cnt_d = 5'd23;
            shreg_d   = next_q[22:0];
            enc_load  = 1'b1;
            enc_bit   = next_q[23];
            if (pix_addr_q != LastIdx) begin
              pix_rd_d   = 1'b1;
              pix_addr_d = pix_addr_q + AddrW'(1);
            end else begin
              pix_rd_d = 1'b0;
            end
          end else begin
            state_d       = ST_LATCH;
            lat_cnt_d     = '0;
            after_frame_d = 1'b1;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_LATCH: begin
        if (lat_cnt_q == LatLast) begin
          state_d       = ST_IDLE;
          frame_done_d  = after_frame_q;
          after_frame_d = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q + LatW'(1);
        end
      end
      default: state_d = ST_LATCH;
    endcase
    start_ready_d = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
  end

  // Reset lands in Latch so the strip sees a full latch time after power-up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_LATCH;
      shreg_q       <= '0;
      next_q        <= '0;
      bit_cnt_q     <= 5'd0;
      pix_idx_q     <= '0;
      pix_addr_q    <= '0;
      pix_rd_q      <= 1'b0;
      cap_q         <= 1'b0;
      lat_cnt_q     <= '0;
      after_frame_q <= 1'b0;
      frame_done_q  <= 1'b0;
      start_ready_q <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      next_q        <= next_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_idx_q     <= pix_idx_d;
      pix_addr_q    <= pix_addr_d;
      pix_rd_q      <= pix_rd_d;
      cap_q         <= cap_d;
      lat_cnt_q     <= lat_cnt_d;
      after_frame_q <= after_frame_d;
      frame_done_q  <= frame_done_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
    end
  end

  ws2812_bit_encoder #(
    .T0hCyc (T0hCyc),
    .T1hCyc (T1hCyc),
    .TBitCyc(TBitCyc)
  ) u_enc (
    .clk     (clk),
    .rst     (rst),
    .load    (enc_load),
    .bit_val (enc_bit),
    .ws      (ws),
    .bit_last(enc_bit_last)
  );

  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign pix_rd      = pix_rd_q;
  assign pix_addr    = pix_addr_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed self-checking bench for ws2812_frame_ctrl with a 3-LED, short-timing build.
// Define WS2812_BRIGHTNESS_EN for both RTL and bench to exercise brightness scaling.
`timescale 1ns/1ps
module tb_ws2812_frame_ctrl;

  localparam int NumLeds = 3;
  localparam int T0h     = 2;
  localparam int T1h     = 4;
  localparam int TBit    = 6;
  localparam int TRst    = 10;
  localparam int AddrW   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic             pix_rd;
  logic [AddrW-1:0] pix_addr;
  logic [23:0]      pix_data = 24'h0;
  logic             ws;
  logic             busy;
  logic             frame_done;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]       brightness = 8'hFF;
`endif

  logic [23:0] ram [0:NumLeds-1];
  int          rd_log [$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [71:0] exp_frame;

  always #5 clk = ~clk;

  ws2812_frame_ctrl #(
    .NumLeds  (NumLeds),
    .T0hCyc   (T0h),
    .T1hCyc   (T1h),
    .TBitCyc  (TBit),
    .TResetCyc(TRst)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .pix_rd     (pix_rd),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .ws         (ws),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Synchronous pixel RAM with one cycle of read latency
  always @(posedge clk) begin
    if (pix_rd) begin
      pix_data <= ram[pix_addr];
      rd_log.push_back(int'(pix_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame from Idle and decodes all 72 bit periods from ws
  task automatic run_frame(output logic [71:0] bits, output int shape_err, output logic rd0,
                           output logic [AddrW-1:0] addr0, output logic ws_wait, output logic ws_rise);
    int   hi;
    logic seen_low;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    rd0 = pix_rd;
    addr0 = pix_addr;
    tick();
    ws_wait = ws;
    tick();
    ws_rise = ws;
    shape_err = 0;
    bits = '0;
    for (int b = 0; b < 72; b++) begin
      hi = 0;
      seen_low = 1'b0;
      for (int j = 0; j < TBit; j++) begin
        if (b != 0 || j != 0) tick();
        if (ws) begin
          hi++;
          if (seen_low) shape_err++;
        end else begin
          seen_low = 1'b1;
        end
      end
      if (hi == T1h) bits = {bits[70:0], 1'b1};
      else if (hi == T0h) bits = {bits[70:0], 1'b0};
      else begin
        shape_err++;
        bits = {bits[70:0], 1'b0};
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if ({ws, pix_rd, pix_addr, frame_done, start_ready, busy} !== {1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values: ws=%b rd=%b addr=%0d done=%b ready=%b busy=%b required 0 0 0 0 0 1",
               ws, pix_rd, pix_addr, frame_done, start_ready, busy);
    end
    for (int i = 1; i <= TRst; i++) begin
      tick();
      n_checks++;
      if ({ws, frame_done, start_ready} !== {1'b0, 1'b0, (i == TRst)}) begin
        n_fail++;
        $display("FAIL powerup_latch cycle %0d: ws=%b done=%b ready=%b required ws=0 done=0 ready=%b",
                 i, ws, frame_done, start_ready, (i == TRst));
      end
    end
  endtask

  task automatic test_frame();
    logic [71:0]      bits;
    int               serr, mark;
    logic             rd0, ws_w, ws_r;
    logic [AddrW-1:0] a0;
    mark = rd_log.size();
    run_frame(bits, serr, rd0, a0, ws_w, ws_r);
    n_checks++;
    if ({rd0, a0, ws_w, ws_r} !== {1'b1, 2'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL frame_latency: rd=%b addr=%0d ws@N+2=%b ws@N+3=%b required 1 0 0 1", rd0, a0, ws_w, ws_r);
    end
    n_checks++;
    if (serr !== 0) begin
      n_fail++;
      $display("FAIL bit_shape: %0d malformed periods, required 0", serr);
    end
    n_checks++;
    if (bits !== exp_frame) begin
      n_fail++;
      $display("FAIL frame_bits: got %018h required %018h", bits, exp_frame);
    end
    n_checks++;
    if (rd_log.size() - mark !== 3) begin
      n_fail++;
      $display("FAIL read_count: got %0d required 3", rd_log.size() - mark);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (rd_log[mark + k] !== k) begin
          n_fail++;
          $display("FAIL read_addr[%0d]: got %0d required %0d", k, rd_log[mark + k], k);
        end
      end
    end
  endtask

  task automatic test_latch();
    for (int i = 1; i <= TRst; i++) begin
      tick();
      n_checks++;
      if ({ws, frame_done, busy} !== 3'b001) begin
        n_fail++;
        $display("FAIL latch_low cycle %0d: ws=%b done=%b busy=%b required 0 0 1", i, ws, frame_done, busy);
      end
    end
    tick();
    n_checks++;
    if ({frame_done, start_ready, ws} !== 3'b110) begin
      n_fail++;
      $display("FAIL frame_done_pulse: done=%b ready=%b ws=%b required 1 1 0", frame_done, start_ready, ws);
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done_width: got %b required 0", frame_done);
    end
  endtask

  task automatic test_back_to_back();
    int mark, n;
    mark = rd_log.size();
    start_valid = 1'b1;
    for (int f = 0; f < 2; f++) begin
      n = 0;
      while (frame_done !== 1'b1 && n < 600) begin
        tick();
        n++;
      end
      n_checks++;
      if (frame_done !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_done[%0d]: timeout, frame_done=%b required 1", f, frame_done);
      end
      if (f == 0) begin
        tick();
        n_checks++;
        if ({pix_rd, pix_addr, busy} !== {1'b1, 2'd0, 1'b1}) begin
          n_fail++;
          $display("FAIL b2b_refetch: rd=%b addr=%0d busy=%b required 1 0 1", pix_rd, pix_addr, busy);
        end
        tick();
        tick();
        n_checks++;
        if (ws !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_gap: ws=%b three cycles after frame_done, required 1", ws);
        end
      end else begin
        start_valid = 1'b0;
      end
    end
    tick();
    n_checks++;
    if ({busy, pix_rd, start_ready} !== 3'b001 || rd_log.size() - mark !== 6) begin
      n_fail++;
      $display("FAIL b2b_no_queue: busy=%b rd=%b ready=%b reads=%0d required 0 0 1 reads=6",
               busy, pix_rd, start_ready, rd_log.size() - mark);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [71:0]      bits;
    int               serr, n;
    logic             rd0, ws_w, ws_r;
    logic [AddrW-1:0] a0;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    n_checks++;
    if (ws !== 1'b1) begin
      n_fail++;
      $display("FAIL pix1_bit5_high: ws=%b required 1", ws);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({ws, busy, start_ready, pix_rd} !== 4'b0100) begin
      n_fail++;
      $display("FAIL async_reset: ws=%b busy=%b ready=%b rd=%b required 0 1 0 0", ws, busy, start_ready, pix_rd);
    end
    tick();
    rst = 1'b0;
    for (int i = 1; i <= TRst; i++) begin
      tick();
      n_checks++;
      if ({ws, frame_done, start_ready} !== {1'b0, 1'b0, (i == TRst)}) begin
        n_fail++;
        $display("FAIL rerun_latch cycle %0d: ws=%b done=%b ready=%b required ws=0 done=0 ready=%b",
                 i, ws, frame_done, start_ready, (i == TRst));
      end
    end
    run_frame(bits, serr, rd0, a0, ws_w, ws_r);
    n_checks++;
    if ({rd0, a0, serr == 0} !== {1'b1, 2'd0, 1'b1} || bits !== exp_frame) begin
      n_fail++;
      $display("FAIL restart_frame: rd=%b addr=%0d shape_err=%0d bits=%018h required 1 0 0 %018h",
               rd0, a0, serr, bits, exp_frame);
    end
    n = 0;
    while (frame_done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done: timeout, frame_done=%b required 1", frame_done);
    end
    tick();
  endtask

`ifdef WS2812_BRIGHTNESS_EN
  task automatic test_brightness();
    logic [71:0]      bits;
    int               serr;
    logic             rd0, ws_w, ws_r;
    logic [AddrW-1:0] a0;
    ram[0] = 24'hFF80FF;
    brightness = 8'h7F;
    run_frame(bits, serr, rd0, a0, ws_w, ws_r);
    brightness = 8'hFF;
    n_checks++;
    if (bits[71:48] !== 24'h7F407F || serr !== 0) begin
      n_fail++;
      $display("FAIL brightness: got %06h shape_err=%0d required 7F407F 0", bits[71:48], serr);
    end
    n_checks++;
    if (bits[23:0] !== 24'h525252) begin
      n_fail++;
      $display("FAIL brightness_px2: got %06h required 525252", bits[23:0]);
    end
  endtask
`endif

  initial begin
    ram[0] = 24'hFF0000;
    ram[1] = 24'h000000;
    ram[2] = 24'hA5A5A5;
    exp_frame = {24'hFF0000, 24'h000000, 24'hA5A5A5};
    test_reset();
    test_frame();
    test_latch();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef WS2812_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
